// File: rtl/literal_pkg.sv
// Shared layout for the literal packer/unpacker pair.
// Packed word: {signed value [VAL_MSB:VAL_LSB], tag [TAG_W-1:0]}.
// Both ends import this package so the field positions can never drift apart.
package literal_pkg;

  localparam int PKT_W   = 12;
  localparam int VAL_MSB = 11;
  localparam int VAL_LSB = 4;
  localparam int TAG_W   = 4;
  localparam int VAL_W   = VAL_MSB - VAL_LSB + 1;

  localparam logic [TAG_W-1:0] TAG_DEFAULT = 4'b1010;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lu_state_e;

  function automatic logic tag_match(input logic [TAG_W-1:0] tag,
                                     input logic [TAG_W-1:0] exp_tag);
    return tag == exp_tag;
  endfunction

endpackage

// File: rtl/literal_sat_acc.sv
// Saturating signed accumulator for the literal unpacker.
// Adds a signed VAL_W-bit value when en_i is high; the sum is formed one bit
// wider than the accumulator and clamped to the signed ACC_W range.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, clears the accumulator
//   en_i     add value_i on this edge
//   value_i  signed addend
//   acc_o    accumulator contents
module literal_sat_acc
  import literal_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [VAL_W-1:0] value_i,
  output logic [ACC_W-1:0] acc_o
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [ACC_W:0]   sum;

  assign sum = (ACC_W+1)'($signed(acc_q)) + (ACC_W+1)'($signed(value_i));

  // The top two bits of the widened sum disagree exactly when the true
  // result falls outside the ACC_W signed range; the top bit gives the side.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/literal_unpacker.sv
// Receive side of the literal-width packer: splits 12-bit {value, tag} words,
// checks the tag, sign-extends the value to OUT_W and holds the result in a
// one-entry registered valid/ready output stage.
// Optional feature: LITERAL_UNPACK_ACCUM_EN builds a saturating running sum of
// matching-tag values on acc_o; without it acc_o is tied to zero.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    upstream handshake and packed word
//   out_valid_o/out_ready_i            downstream handshake
//   out_value_o, out_tag_o, out_tag_ok_o   registered decoded word
//   err_cnt_o           saturating count of accepted tag mismatches
//   acc_o               saturating signed running sum (or zero)
//
// state | meaning
// EMPTY | output register holds no word; input always ready
// FULL  | output register holds a word; input ready only when it pops
module literal_unpacker
  import literal_pkg::*;
#(
  parameter int               OUT_W     = 16,
  parameter logic [TAG_W-1:0] TAG       = TAG_DEFAULT,
  parameter int               ERR_CNT_W = 8,
  parameter int               ACC_W     = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PKT_W-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_W-1:0]     out_value_o,
  output logic [TAG_W-1:0]     out_tag_o,
  output logic                 out_tag_ok_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ACC_W-1:0]     acc_o
);

  lu_state_e state_q, state_d;

  logic                 accept;
  logic                 pop;
  logic                 tag_ok_in;
  logic [OUT_W-1:0]     value_q, value_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 tag_ok_q, tag_ok_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  // Ready passes out_ready straight through so a full stage can swap words
  // every cycle without a bubble.
  assign in_ready_o  = !rst_i && ((state_q == EMPTY) || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == FULL);
  assign pop         = out_valid_o && out_ready_i;
  assign tag_ok_in   = tag_match(in_data_i[TAG_W-1:0], TAG);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept)         state_d = FULL;
      FULL:  if (pop && !accept) state_d = EMPTY;
    endcase
  end

  always_comb begin
    value_d  = value_q;
    tag_d    = tag_q;
    tag_ok_d = tag_ok_q;
    err_d    = err_q;
    if (accept) begin
      // Size cast of a signed operand sign-extends the value field.
      value_d  = OUT_W'($signed(in_data_i[VAL_MSB:VAL_LSB]));
      tag_d    = in_data_i[TAG_W-1:0];
      tag_ok_d = tag_ok_in;
      if (!tag_ok_in && (err_q != {ERR_CNT_W{1'b1}})) begin
        err_d = err_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      value_q  <= '0;
      tag_q    <= '0;
      tag_ok_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      tag_q    <= tag_d;
      tag_ok_q <= tag_ok_d;
      err_q    <= err_d;
    end
  end

  assign out_value_o  = value_q;
  assign out_tag_o    = tag_q;
  assign out_tag_ok_o = tag_ok_q;
  assign err_cnt_o    = err_q;

`ifdef LITERAL_UNPACK_ACCUM_EN
  literal_sat_acc #(
    .ACC_W(ACC_W)
  ) u_sat_acc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (accept && tag_ok_in),
    .value_i (in_data_i[VAL_MSB:VAL_LSB]),
    .acc_o   (acc_o)
  );
`else
  assign acc_o = '0;
`endif

endmodule

// File: tb/tb_literal_unpacker.sv
module tb_literal_unpacker;

  localparam int OUT_W     = 16;
  localparam int ERR_CNT_W = 2;
  localparam int ACC_W     = 8;
  localparam int ACC_MAXV  = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MINV  = -(1 << (ACC_W - 1));
  localparam int ERR_MAXV  = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [11:0]          in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_value;
  logic [3:0]           out_tag;
  logic                 out_tag_ok;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0]     acc;

  int total = 0;
  int bad   = 0;

  literal_unpacker #(
    .OUT_W(OUT_W), .TAG(4'b1010), .ERR_CNT_W(ERR_CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_value_o(out_value), .out_tag_o(out_tag), .out_tag_ok_o(out_tag_ok),
    .err_cnt_o(err_cnt), .acc_o(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int acc_exp(input int v);
`ifdef LITERAL_UNPACK_ACCUM_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Behavioural model: a one-slot buffer with counters, stepped per edge.
  bit               m_full = 0;
  logic [OUT_W-1:0] m_value = '0;
  logic [3:0]       m_tag = '0;
  bit               m_ok = 0;
  int               m_err = 0;
  int               m_acc = 0;
  logic [OUT_W-1:0] dut_pops[$];

  always @(posedge clk) begin
    bit take, give;
    int v;
    // DUT registers still hold pre-edge values in the active region.
    if (!rst && out_valid && out_ready) dut_pops.push_back(out_value);
    if (rst) begin
      m_full = 0; m_value = '0; m_tag = '0; m_ok = 0; m_err = 0; m_acc = 0;
    end else begin
      give = m_full && out_ready;
      take = in_valid && (!m_full || out_ready);
      if (take) begin
        v       = int'($signed(in_data[11:4]));
        m_value = OUT_W'(v);
        m_tag   = in_data[3:0];
        m_ok    = (in_data[3:0] == 4'b1010);
        if (!m_ok && m_err < ERR_MAXV) m_err = m_err + 1;
`ifdef LITERAL_UNPACK_ACCUM_EN
        if (m_ok) begin
          m_acc = m_acc + v;
          if (m_acc > ACC_MAXV) m_acc = ACC_MAXV;
          if (m_acc < ACC_MINV) m_acc = ACC_MINV;
        end
`endif
        m_full = 1;
      end else if (give) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("in_ready", 32'(in_ready), 32'(!rst && (!m_full || out_ready)));
    if (m_full) begin
      chk("out_value", 32'(out_value), 32'(m_value));
      chk("out_tag", 32'(out_tag), 32'(m_tag));
      chk("out_tag_ok", 32'(out_tag_ok), 32'(m_ok));
    end
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("acc", 32'(int'($signed(acc))), 32'(m_acc));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    cyc();
    rst = 0;
  endtask

  logic [OUT_W-1:0] exp_pops [4];

  initial begin
    exp_pops = '{16'hFFFB, 16'hFF80, 16'h0001, 16'h0002};
    rst = 1; in_valid = 0; out_ready = 0; in_data = '0;
    cyc(); cyc();
    rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_value", 32'(out_value), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_acc", 32'(acc), 0);

    // basic decode
    out_ready = 1; in_data = 12'hFBA; in_valid = 1;
    cyc();
    in_valid = 0;
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_value", 32'(out_value), 32'h0000FFFB);
    chk("basic_tag", 32'(out_tag), 32'hA);
    chk("basic_ok", 32'(out_tag_ok), 1);
    chk("basic_err", 32'(err_cnt), 0);
    chk("basic_acc", 32'(int'($signed(acc))), 32'(acc_exp(-5)));
    cyc();

    // mismatch + most negative value
    in_data = 12'h805; in_valid = 1;
    cyc();
    in_valid = 0;
    chk("mis_value", 32'(out_value), 32'h0000FF80);
    chk("mis_ok", 32'(out_tag_ok), 0);
    chk("mis_err", 32'(err_cnt), 1);
    cyc();

    // backpressure
    out_ready = 0; in_data = 12'h01A; in_valid = 1;
    cyc();
    in_data = 12'h02A;
    chk("bp_ready", 32'(in_ready), 0);
    cyc();
    chk("bp_hold1", 32'(out_value), 32'h0001);
    cyc();
    chk("bp_hold2", 32'(out_value), 32'h0001);
    chk("bp_valid", 32'(out_valid), 1);
    out_ready = 1;
    cyc();
    in_valid = 0;
    chk("swap_valid", 32'(out_valid), 1);
    chk("swap_value", 32'(out_value), 32'h0002);
    chk("swap_acc", 32'(int'($signed(acc))), 32'(acc_exp(-2)));
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    chk("pop_count", 32'(dut_pops.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_pops.size()) chk("pop_value", 32'(dut_pops[i]), 32'(exp_pops[i]));
    end

    // err_cnt saturation
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = {8'(i), 4'h3}; in_valid = 1;
      cyc();
      chk("err_sat", 32'(err_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    in_valid = 0;

    // positive accumulator saturation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_data = 12'h7FA; in_valid = 1;
      cyc();
    end
    in_valid = 0;
    chk("acc_pos", 32'(int'($signed(acc))), 32'(acc_exp(127)));
    chk("val_pos", 32'(out_value), 32'h007F);

    // negative accumulator saturation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_data = 12'h80A; in_valid = 1;
      cyc();
    end
    in_valid = 0;
    chk("acc_neg", 32'(int'($signed(acc))), 32'(acc_exp(-128)));
    chk("val_neg", 32'(out_value), 32'h0000FF80);

    // reset while full, with a word offered
    do_reset();
    out_ready = 1;
    in_data = 12'h005; in_valid = 1; cyc();
    in_data = 12'h006; cyc();
    out_ready = 0; in_data = 12'h007; cyc();
    chk("mid_err", 32'(err_cnt), 2);
    chk("mid_valid", 32'(out_valid), 1);
    rst = 1; out_ready = 1; in_data = 12'h0FA; in_valid = 1;
    cyc();
    rst = 0; in_valid = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_err", 32'(err_cnt), 0);
    chk("mid_rst_acc", 32'(acc), 0);
    chk("mid_rst_value", 32'(out_value), 0);
    cyc();
    chk("mid_after_valid", 32'(out_valid), 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/literal_unpacker.md
# literal_unpacker

Receive-side counterpart of the literal-width packer. Accepts 12-bit packed words laid out as {signed 8-bit value, 4-bit tag}, checks the tag against a constant, and sign-extends the value to a configurable width. Presents the result through a one-entry registered valid/ready output stage. Sits directly downstream of any block producing the {s_neg, c_bin} style concatenation.

## Interface
- OUT_W, 16: output value width; legal range ≥ 8.
- TAG, 4'b1010: expected tag literal.
- ERR_CNT_W, 8: width of the tag-mismatch counter.
- ACC_W, 20: accumulator width; legal range ≥ 8.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  upstream may transfer this cycle.
- in_data  input  12  packed word; [11:4] is the signed value, [3:0] is the tag.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts this cycle.
- out_value  output  OUT_W  sign-extended in_data[11:4].
- out_tag  output  4  in_data[3:0] as received.
- out_tag_ok  output  1  out_tag == TAG.
- err_cnt  output  ERR_CNT_W  saturating count of accepted words with a tag mismatch.
- acc  output  ACC_W  saturating signed running sum (see Configuration); zero when the feature is compiled out.

## Operation
- Transfer in: accept = in_valid && in_ready. Transfer out: pop = out_valid && out_ready.
- in_ready = !rst && (state == EMPTY || out_ready). This is a combinational pass-through of out_ready.
- Two-state FSM:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on pop without accept.
  - FULL stays FULL on pop with accept; the register is replaced by the new word in the same edge.
  - FULL with no pop holds the register stable; no input is accepted.
- On accept, load the output register:
  - out_value = {{(OUT_W-8){in_data[11]}}, in_data[11:4]}.
  - out_tag = in_data[3:0].
  - out_tag_ok = (in_data[3:0] == TAG).
- out_valid = (state == FULL).
- err_cnt increments by 1 on each accept with a tag mismatch. It saturates at all-ones and never wraps.
- Extremes:
  - Value field 8'h80 gives −128, which is {(OUT_W-8){1'b1}, 8'h80}.
  - Value field 8'h7F gives +127, zero-extended.
- Payload outputs are don't-care while out_valid is 0. They hold their last loaded value.

## Timing
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N. Throughput is one word per cycle when out_ready is held at 1.
- While out_valid = 1 and out_ready = 0, out_value, out_tag and out_tag_ok are stable.
- err_cnt and acc update on the same edge as the accept.
- Reset:
  - On an edge with rst = 1, state = EMPTY and out_valid = 0.
  - out_value = 0, out_tag = 0, out_tag_ok = 0, err_cnt = 0, acc = 0.
  - in_ready = 0 while rst is high. No word is accepted during reset.
- Reset mid-operation discards a held word. Reset has priority over a simultaneous accept or pop.

## Configuration
- LITERAL_UNPACK_ACCUM_EN defined:
  - On each accept with a matching tag, acc += sign-extended value, computed signed in ACC_W+1 bits.
  - The result is clamped to the range [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Words with a tag mismatch do not change acc.
- LITERAL_UNPACK_ACCUM_EN undefined:
  - No accumulator logic is built.
  - acc is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package literal_pkg holds:
  - Packed-word constants: PKT_W = 12, VAL_MSB = 11, VAL_LSB = 4, TAG_W = 4.
  - Default TAG literal 4'b1010.
  - The FSM state enum {EMPTY, FULL}.
  - The packer uses the same package, so both ends agree on the layout.
- One sub-module, literal_sat_acc, holds the saturating signed accumulator. It is instantiated only under LITERAL_UNPACK_ACCUM_EN.

## Test plan
- Basic decode: rst for 2 cycles, then in_data = 12'hFBA with out_ready = 1 → next cycle out_valid = 1, out_value = 16'hFFFB, out_tag = 4'hA, out_tag_ok = 1, err_cnt = 0.
- Mismatch and extreme value: in_data = 12'h805 → out_value = 16'hFF80, out_tag_ok = 0, err_cnt = 1.
- Backpressure:
  - Stimulus: out_ready = 0, words 12'h01A then 12'h02A offered back-to-back.
  - While stalled: out_value = 16'h0001 held stable; in_ready = 0, so the second word is stalled.
  - After out_ready rises: 16'h0001 pops, then 16'h0002. No loss, no duplication.
- Simultaneous pop and accept: FULL state, out_ready = 1 and in_valid = 1 on the same cycle → out_valid stays 1 and the register updates to the new word.
- Saturation, with ERR_CNT_W = 2 and, under the macro, ACC_W = 8:
  - 5 words with a tag mismatch → err_cnt = 3.
  - Three 12'h7FA words → acc = 127.
  - Three 12'h80A words from reset → acc = −128.
  - Without the macro, acc = 0 throughout.
- Reset mid-operation: FULL with err_cnt = 2, then rst pulsed for one cycle with in_valid = 1 → after that edge, out_valid = 0, err_cnt = 0, acc = 0, and no word was captured.
